// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit for a word-wide,
//               big-endian synchronous RAM with one cycle of read latency.
//               Checks alignment and range, places store bytes into lanes
//               and formats/extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int kAddrLimit = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_badaddr,
  output logic        ram_en,
  output logic [3:0]  ram_write_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [2:0]  c_OP_LB  = 3'b000;
  localparam logic [2:0]  c_OP_LH  = 3'b001;
  localparam logic [2:0]  c_OP_LW  = 3'b010;
  localparam logic [2:0]  c_OP_LBU = 3'b011;
  localparam logic [2:0]  c_OP_LHU = 3'b100;
  localparam logic [2:0]  c_OP_SB  = 3'b101;
  localparam logic [2:0]  c_OP_SH  = 3'b110;
  localparam logic [2:0]  c_OP_SW  = 3'b111;

  localparam logic [1:0]  c_ERR_NONE     = 2'b00;
  localparam logic [1:0]  c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  c_ERR_RANGE    = 2'b10;

  localparam logic [31:0] c_ADDR_LIMIT = kAddrLimit[31:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_err;
  logic [31:0] r_resp_badaddr;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic [1:0]  w_req_err;
  logic        w_is_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign req_ready  = (r_state == IDLE) && rst;
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == RESP);

  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign resp_badaddr = r_resp_badaddr;

  assign w_is_store = (r_op == c_OP_SB) || (r_op == c_OP_SH) || (r_op == c_OP_SW);

  // Alignment check on the incoming request, by access size.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_op)
      c_OP_LH, c_OP_LHU, c_OP_SH: w_misaligned = req_addr[0];
      c_OP_LW, c_OP_SW:           w_misaligned = |req_addr[1:0];
      default:                    w_misaligned = 1'b0;
    endcase
  end

  assign w_out_of_range = (req_addr >= c_ADDR_LIMIT);
  // Misalignment outranks range so a misaligned far address reports 01.
  assign w_req_err = w_misaligned   ? c_ERR_MISALIGN :
                     w_out_of_range ? c_ERR_RANGE    : c_ERR_NONE;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic and RAM port drive (RAM is only touched in ISSUE).
  always_comb begin
    w_next_state  = r_state;
    ram_en        = 1'b0;
    ram_write_sel = 4'b0000;
    ram_addr      = 32'h0;
    ram_wdata     = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = (w_req_err == c_ERR_NONE) ? ISSUE : RESP;
      end
      ISSUE: begin
        w_next_state = WAIT;
        ram_en       = 1'b1;
        ram_addr     = {r_addr[31:2], 2'b00};
        case (r_op)
          c_OP_SB: begin
            ram_write_sel = 4'b1000 >> r_addr[1:0];
            ram_wdata     = {4{r_wdata[7:0]}};
          end
          c_OP_SH: begin
            ram_write_sel = r_addr[1] ? 4'b0011 : 4'b1100;
            ram_wdata     = {2{r_wdata[15:0]}};
          end
          c_OP_SW: begin
            ram_write_sel = 4'b1111;
            ram_wdata     = r_wdata;
          end
          default: begin
            ram_write_sel = 4'b0000;
            ram_wdata     = 32'h0;
          end
        endcase
      end
      WAIT:    w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the request on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= 3'b000;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_op    <= req_op;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Big-endian lane selection and sign/zero extension of the read word.
  always_comb begin
    w_byte      = 8'h00;
    w_load_data = 32'h0;
    case (r_addr[1:0])
      2'd0:    w_byte = ram_rdata[31:24];
      2'd1:    w_byte = ram_rdata[23:16];
      2'd2:    w_byte = ram_rdata[15:8];
      default: w_byte = ram_rdata[7:0];
    endcase
    w_half = r_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (r_op)
      c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_load_data = {24'h0, w_byte};
      c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_load_data = {16'h0, w_half};
      c_OP_LW:  w_load_data = ram_rdata;
      default:  w_load_data = 32'h0;
    endcase
  end

  // Response registers: loaded on entry to RESP and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_rdata   <= 32'h0;
      r_resp_err     <= c_ERR_NONE;
      r_resp_badaddr <= 32'h0;
    end else if ((r_state == IDLE) && w_accept && (w_req_err != c_ERR_NONE)) begin
      r_resp_rdata   <= 32'h0;
      r_resp_err     <= w_req_err;
      r_resp_badaddr <= req_addr;
    end else if (r_state == WAIT) begin
      r_resp_rdata   <= w_is_store ? 32'h0 : w_load_data;
      r_resp_err     <= c_ERR_NONE;
      r_resp_badaddr <= 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word RAM
//               and a byte-addressed reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] resp_badaddr;
  logic        ram_en;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          lat;
    logic [31:0] rd;
    logic [1:0]  err;
    logic [31:0] bad;
    int          en_cnt;
    logic [3:0]  sel;
    logic [31:0] raddr;
    logic [31:0] rwd;
  } res_t;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_badaddr(resp_badaddr),
    .ram_en(ram_en), .ram_write_sel(ram_write_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Word RAM: one-cycle read latency, byte-lane writes, 128 words.
  logic [31:0] mem [0:127];
  logic [31:0] init_words [0:127];
  logic        do_init = 1'b0;
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_words[i];
    end else if (ram_en && (ram_addr < 32'd512)) begin
      ram_rdata <= mem[ram_addr[8:2]];
      for (int k = 0; k < 4; k++)
        if (ram_write_sel[k]) mem[ram_addr[8:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Reference model: flat byte array, byte 0 of a word is its MSB.
  logic [7:0] ref_mem [0:511];

  function automatic logic [1:0] ref_err(logic [2:0] op, logic [31:0] a);
    bit half = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    bit word = (op == 3'd2) || (op == 3'd7);
    if ((half && a[0]) || (word && (a[1:0] != 2'b00))) return 2'b01;
    if (a >= 32'd512) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] a);
    int i = int'(a[8:0]);
    case (op)
      3'd0: return {{24{ref_mem[i][7]}}, ref_mem[i]};
      3'd3: return {24'h0, ref_mem[i]};
      3'd1: return {{16{ref_mem[i][7]}}, ref_mem[i], ref_mem[i+1]};
      3'd4: return {16'h0, ref_mem[i], ref_mem[i+1]};
      3'd2: return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int op_bytes(logic [2:0] op);
    case (op)
      3'd5: return 1;
      3'd6: return 2;
      3'd7: return 4;
      default: return 0;
    endcase
  endfunction

  // Lanes touched by a store: byte at offset o lands in lane 3-o.
  function automatic logic [3:0] ref_sel(logic [2:0] op, logic [31:0] a);
    logic [3:0] s = 4'b0000;
    for (int b = 0; b < op_bytes(op); b++) s[3 - (int'(a[1:0]) + b)] = 1'b1;
    return s;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int i = int'(a[8:0]);
    int n = op_bytes(op);
    for (int b = 0; b < n; b++) ref_mem[i+b] = wd[8*(n-1-b) +: 8];
  endtask

  task automatic pick_valid(output logic [2:0] op, output logic [31:0] a, output logic [31:0] wd);
    op = 3'($urandom_range(0, 7));
    a  = 32'($urandom_range(0, 511));
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) a[0] = 1'b0;
    if (op == 3'd2 || op == 3'd7) a[1:0] = 2'b00;
    wd = $urandom;
  endtask

  // Drive one op and observe it until its response (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output res_t r);
    int n;
    r.lat = 0; r.rd = '0; r.err = '0; r.bad = '0; r.en_cnt = 0;
    r.sel = '0; r.raddr = '0; r.rwd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_en === 1'b1) begin
        r.en_cnt++;
        r.sel = ram_write_sel; r.raddr = ram_addr; r.rwd = ram_wdata;
      end
      if (resp_valid === 1'b1) begin
        r.lat = i; r.rd = resp_rdata; r.err = resp_err; r.bad = resp_badaddr;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [136:0] outs;
    @(negedge clk);
    outs = {req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr,
            ram_en, ram_write_sel, ram_addr, ram_wdata};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_sw_lw;
    res_t r;
    do_op(3'd7, 32'h10, 32'h11223344, r);
    ref_store(3'd7, 32'h10, 32'h11223344);
    n_cmp++; if (r.sel !== 4'b1111) begin n_bad++; $display("FAIL sw_sel: got %b expected 1111", r.sel); end
    n_cmp++; if (r.raddr !== 32'h10) begin n_bad++; $display("FAIL sw_addr: got %h expected 10", r.raddr); end
    n_cmp++; if (r.rwd !== 32'h11223344) begin n_bad++; $display("FAIL sw_wdata: got %h expected 11223344", r.rwd); end
    n_cmp++; if (r.lat != 3) begin n_bad++; $display("FAIL sw_latency: got %0d expected 3", r.lat); end
    n_cmp++; if ({r.rd, r.err} !== 34'h0) begin n_bad++; $display("FAIL sw_resp: got %h/%b expected 0/00", r.rd, r.err); end
    do_op(3'd2, 32'h10, 32'h0, r);
    n_cmp++; if (r.rd !== 32'h11223344) begin n_bad++; $display("FAIL lw_data: got %h expected 11223344", r.rd); end
    n_cmp++; if (r.sel !== 4'b0000) begin n_bad++; $display("FAIL lw_sel: got %b expected 0000", r.sel); end
  endtask

  task automatic test_byte;
    res_t r;
    do_op(3'd5, 32'h13, 32'h000000AB, r);
    ref_store(3'd5, 32'h13, 32'h000000AB);
    n_cmp++; if (r.sel !== 4'b0001) begin n_bad++; $display("FAIL sb_sel: got %b expected 0001", r.sel); end
    n_cmp++; if (r.rwd !== 32'hABABABAB) begin n_bad++; $display("FAIL sb_wdata: got %h expected abababab", r.rwd); end
    do_op(3'd0, 32'h13, 32'h0, r);
    n_cmp++; if (r.rd !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL lb_data: got %h expected ffffffab", r.rd); end
    do_op(3'd3, 32'h13, 32'h0, r);
    n_cmp++; if (r.rd !== 32'h000000AB) begin n_bad++; $display("FAIL lbu_data: got %h expected 000000ab", r.rd); end
  endtask

  task automatic test_half;
    res_t r;
    do_op(3'd6, 32'h22, 32'h00008001, r);
    ref_store(3'd6, 32'h22, 32'h00008001);
    n_cmp++; if (r.sel !== 4'b0011) begin n_bad++; $display("FAIL sh_sel: got %b expected 0011", r.sel); end
    n_cmp++; if (r.rwd !== 32'h80018001) begin n_bad++; $display("FAIL sh_wdata: got %h expected 80018001", r.rwd); end
    do_op(3'd1, 32'h22, 32'h0, r);
    n_cmp++; if (r.rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_data: got %h expected ffff8001", r.rd); end
    do_op(3'd4, 32'h22, 32'h0, r);
    n_cmp++; if (r.rd !== 32'h00008001) begin n_bad++; $display("FAIL lhu_data: got %h expected 00008001", r.rd); end
  endtask

  task automatic test_errors;
    res_t r;
    do_op(3'd2, 32'h06, 32'h0, r);
    n_cmp++; if (r.lat != 1) begin n_bad++; $display("FAIL mis_latency: got %0d expected 1", r.lat); end
    n_cmp++; if (r.err !== 2'b01) begin n_bad++; $display("FAIL mis_err: got %b expected 01", r.err); end
    n_cmp++; if (r.bad !== 32'h06) begin n_bad++; $display("FAIL mis_badaddr: got %h expected 6", r.bad); end
    n_cmp++; if (r.en_cnt != 0) begin n_bad++; $display("FAIL mis_ram_en: got %0d cycles expected 0", r.en_cnt); end
    n_cmp++; if (r.rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h expected 0", r.rd); end
    do_op(3'd2, 32'h200, 32'h0, r);
    n_cmp++; if (r.err !== 2'b10) begin n_bad++; $display("FAIL range_err: got %b expected 10", r.err); end
    n_cmp++; if (r.bad !== 32'h200) begin n_bad++; $display("FAIL range_badaddr: got %h expected 200", r.bad); end
    n_cmp++; if (r.en_cnt != 0) begin n_bad++; $display("FAIL range_ram_en: got %0d cycles expected 0", r.en_cnt); end
  endtask

  task automatic test_random;
    res_t r;
    logic [2:0]  op;
    logic [31:0] a, wd, exp_rd;
    logic [1:0]  e;
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h23F));
      wd = $urandom;
      e  = ref_err(op, a);
      do_op(op, a, wd, r);
      n_cmp++; if (r.err !== e) begin n_bad++; $display("FAIL rnd_err op%0d @%h: got %b expected %b", op, a, r.err, e); end
      n_cmp++; if (r.lat != ((e != 2'b00) ? 1 : 3)) begin n_bad++; $display("FAIL rnd_latency op%0d @%h: got %0d", op, a, r.lat); end
      n_cmp++; if (r.en_cnt != ((e != 2'b00) ? 0 : 1)) begin n_bad++; $display("FAIL rnd_ram_en op%0d @%h: got %0d cycles", op, a, r.en_cnt); end
      if (e != 2'b00) begin
        n_cmp++; if ({r.bad, r.rd} !== {a, 32'h0}) begin n_bad++; $display("FAIL rnd_errresp @%h: got %h/%h", a, r.bad, r.rd); end
      end else begin
        exp_rd = ref_load(op, a);
        if (op_bytes(op) != 0) ref_store(op, a, wd);
        n_cmp++; if (r.rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata op%0d @%h: got %h expected %h", op, a, r.rd, exp_rd); end
        n_cmp++; if ({r.sel, r.raddr} !== {ref_sel(op, a), a[31:2], 2'b00}) begin
          n_bad++; $display("FAIL rnd_ramport op%0d @%h: got %b/%h", op, a, r.sel, r.raddr);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q_rd[$];
    logic [2:0]  op;
    logic [31:0] a, wd;
    int ready_cnt = 0, last = -1, gap_bad = 0, got = 0;
    bit acc;
    @(negedge clk);
    pick_valid(op, a, wd);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    for (int c = 0; c < 48; c++) begin
      acc = 1'b0;
      if (resp_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (q_rd.size() == 0) begin
          n_bad++; $display("FAIL b2b_unexpected_resp: got %h expected none", resp_rdata);
        end else if ({resp_rdata, resp_err} !== {q_rd[0], 2'b00}) begin
          n_bad++; $display("FAIL b2b_resp_order: got %h/%b expected %h/00", resp_rdata, resp_err, q_rd[0]);
        end
        if (q_rd.size() != 0) void'(q_rd.pop_front());
      end
      if (req_ready === 1'b1 && c < 40) begin
        ready_cnt++;
        if (last >= 0 && (c - last) != 4) gap_bad++;
        last = c;
        q_rd.push_back(ref_load(op, a));
        if (op_bytes(op) != 0) ref_store(op, a, wd);
        acc = 1'b1;
      end
      if (c == 40) req_valid = 1'b0;
      @(posedge clk);
      #1;
      if (acc) begin
        pick_valid(op, a, wd);
        req_op = op; req_addr = a; req_wdata = wd;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (ready_cnt != 10) begin n_bad++; $display("FAIL b2b_ready_count: got %0d expected 10", ready_cnt); end
    n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL b2b_ready_spacing: got %0d bad gaps expected 0", gap_bad); end
    n_cmp++; if (got != 10) begin n_bad++; $display("FAIL b2b_resp_count: got %0d expected 10", got); end
  endtask

  task automatic test_reset_mid;
    res_t r;
    logic [136:0] outs;
    int n = 0, viol = 0;
    logic [31:0] a = 32'h44;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_addr = a; req_wdata = 32'h0;
    while (req_ready !== 1'b1 && n < 16) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);  // ISSUE
    @(negedge clk);  // WAIT
    #2 rst = 1'b0;
    #1;
    outs = {req_ready, resp_valid, resp_rdata, resp_err, resp_badaddr,
            ram_en, ram_write_sel, ram_addr, ram_wdata};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || ram_en !== 1'b0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", viol); end
    rst = 1'b1;
    do_op(3'd2, a, 32'h0, r);
    n_cmp++; if (r.rd !== ref_load(3'd2, a)) begin n_bad++; $display("FAIL midreset_lw: got %h expected %h", r.rd, ref_load(3'd2, a)); end
    n_cmp++; if (r.lat != 3) begin n_bad++; $display("FAIL midreset_latency: got %0d expected 3", r.lat); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 128; i++) begin
      init_words[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = init_words[i][8*(3-b) +: 8];
    end
    do_init = 1'b1;
    @(posedge clk);
    #1 do_init = 1'b0;
    test_reset;
    test_sw_lw;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: kAddrLimit, default 512, the first byte address the backing RAM does not serve.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1, the pipeline offers a memory op.
REQ-005 The block SHALL have port req_ready, output, 1, the block accepts an op this cycle.
REQ-006 The block SHALL have port req_op, input, 3, the op code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-007 The block SHALL have port req_addr, input, 32, the byte address.
REQ-008 The block SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-009 The block SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port resp_rdata, output, 32, the formatted load result.
REQ-011 The block SHALL have port resp_err, output, 2, the error code: 00 none, 01 misaligned, 10 out of range.
REQ-012 The block SHALL have port resp_badaddr, output, 32, the faulting address, valid when resp_err is not 00.
REQ-013 The block SHALL have port ram_en, output, 1, the RAM enable.
REQ-014 The block SHALL have port ram_write_sel, output, 4, the byte-lane write enables; bit 3 = data[31:24].
REQ-015 The block SHALL have port ram_addr, output, 32, the word-aligned RAM address with bits [1:0] = 00.
REQ-016 The block SHALL have port ram_wdata, output, 32, the lane-placed store data.
REQ-017 The block SHALL have port ram_rdata, input, 32, the RAM read data, valid on the cycle after the read-enable cycle.

Function
REQ-018 The block SHALL use four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE with rst high; an op SHALL be accepted on a rising edge where req_valid and req_ready are both 1, and op, address and data SHALL be latched.
REQ-020 IDLE SHALL transition to ISSUE when an aligned, in-range op is accepted.
REQ-021 IDLE SHALL transition to RESP when the accepted op is misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00), giving resp_err=01; misaligned takes priority over out of range.
REQ-022 IDLE SHALL transition to RESP when an aligned op has addr >= kAddrLimit, giving resp_err=10.
REQ-023 An errored op SHALL cause no RAM activity, resp_rdata SHALL be 0, and resp_badaddr SHALL equal the latched address.
REQ-024 ISSUE SHALL last exactly one cycle with ram_en=1 and ram_addr={addr[31:2],2'b00}; ram_write_sel SHALL be 0000 for loads.
REQ-025 SB SHALL drive ram_write_sel = 1000 >> addr[1:0] and ram_wdata = the low byte of req_wdata replicated into all four lanes.
REQ-026 SH SHALL drive ram_write_sel = 1100 for offset 0 and 0011 for offset 2, with ram_wdata = {wdata[15:0], wdata[15:0]}.
REQ-027 SW SHALL drive ram_write_sel = 1111 and ram_wdata = wdata.
REQ-028 Outside ISSUE, ram_en, ram_write_sel, ram_addr and ram_wdata SHALL all be 0.
REQ-029 WAIT SHALL last one cycle; for loads, ram_rdata SHALL be sampled and formatted into the response register, and for stores it SHALL be a commit gap so no following access overlaps the RAM's delayed write.
REQ-030 Byte lane selection SHALL be big-endian: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
REQ-031 LB SHALL sign-extend the selected byte and LBU SHALL zero-extend it.
REQ-032 For LH/LHU, offset 0 SHALL select [31:16] and offset 2 SHALL select [15:0]; LH SHALL sign-extend and LHU SHALL zero-extend.
REQ-033 LW SHALL pass ram_rdata through unchanged.
REQ-034 RESP SHALL drive resp_valid=1 for exactly one cycle, then transition to IDLE; stores SHALL report resp_rdata=0 and resp_err=00.
REQ-035 Latency from the acceptance edge to resp_valid SHALL be 3 cycles for valid ops and 1 cycle for errored ops; throughput SHALL be one op per 4 cycles.
REQ-036 resp_rdata, resp_err and resp_badaddr SHALL hold their values until the next RESP.
REQ-037 req_valid SHALL be ignored outside IDLE, and no op SHALL be dropped once accepted.

Reset
REQ-038 While rst=0, the state SHALL be IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=00, resp_badaddr=0, and all ram_* outputs SHALL be 0.
REQ-039 Reset asserted mid-operation SHALL abort the op immediately, with no response and no further RAM enable.
REQ-040 A store aborted after ISSUE MAY already have committed in the RAM.
REQ-041 Operation SHALL resume in IDLE on the first edge after rst rises.

Verification
REQ-042 The bench SHALL cover: SW 0x11223344 @0x10 -> ISSUE shows sel=1111, addr=0x10; resp_valid 3 cycles after acceptance; then LW @0x10 -> resp_rdata=0x11223344.
REQ-043 The bench SHALL cover: SB 0x000000AB @0x13 -> sel=0001, wdata=0xABABABAB; then LB @0x13 -> 0xFFFFFFAB and LBU @0x13 -> 0x000000AB.
REQ-044 The bench SHALL cover: SH 0x8001 @0x22 -> sel=0011; then LH @0x22 -> 0xFFFF8001 and LHU @0x22 -> 0x00008001.
REQ-045 The bench SHALL cover: LW @0x06 -> resp_valid 1 cycle after acceptance, resp_err=01, badaddr=0x06, ram_en never high; LW @0x200 -> resp_err=10.
REQ-046 The bench SHALL cover: req_valid held high across back-to-back ops -> req_ready=1 exactly one cycle in four, with responses in request order.
REQ-047 The bench SHALL cover: rst pulled low during WAIT of a load -> all outputs 0 at once, no resp_valid; after release, a new LW completes normally.
